fp_image_loader: RTL and testbench
==================================

Name: fp_image_loader

Overview:
- Synthesizable, parametrised loader that replaces hand-sequenced Load_PC/Deposit testbench tasks.
- Accepts a stream of (address, data) memory-image words over a valid/ready handshake and buffers them in a small FIFO.
- Drives the Front_Panel switch and button inputs with programmable hold times to deposit each word, then loads the start address and raises the run switch.
- Watches the run LED to report program completion.
- New capability: skips the Load-PC step when the address is contiguous, because Deposit auto-increments PC.

Parameters:
- WORD_W, 12, address and data width.
- HOLD_CYCLES, 10, cycles each switch/button phase is held (≥1).
- FIFO_DEPTH, 4, input buffer entries (power of 2, ≥2).
- START_ADDR, 12'o0200, PC loaded before run.
- CNT_W, 13, width of the words_loaded counter.

Ports:
- clock  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- in_valid  in  1  an image word is offered.
- in_ready  out  1  FIFO not full; a transfer occurs when in_valid && in_ready.
- in_addr  in  WORD_W  word address.
- in_data  in  WORD_W  word data.
- in_last  in  1  final word of the image.
- sw_data  out  WORD_W  front-panel switches sw[WORD_W-1:0].
- run_sw  out  1  front-panel run switch (sw[12]).
- load_pc_btn  out  1  Load-PC button.
- deposit_btn  out  1  Deposit button.
- run_led  in  1  CPU running indicator (led[12]).
- busy  out  1  loader is sequencing.
- done  out  1  program finished; sticky until reset.
- words_loaded  out  CNT_W  count of deposits, saturating.

Behaviour:
- Reset (asynchronous, any state): all outputs 0 except in_ready=1. FIFO emptied, FSM in IDLE, first_word=1, exp_pc=0. A reset mid-sequence drops every button the same cycle.
- FIFO:
  - Write on in_valid&&in_ready; read when the FSM pops in IDLE.
  - in_ready = !full. Simultaneous push and pop when full is not allowed, since in_ready is already low.
  - Stores {last, addr, data}.
- Phase timer: every phase below lasts exactly HOLD_CYCLES cycles. The counter reloads on each phase entry.
- FSM states: IDLE, A_SET, A_PRESS, A_REL, D_SET, D_PRESS, D_REL, S_SET, S_PRESS, S_REL, RUN_ARM, RUNNING, DONE.
- IDLE:
  - If the FIFO is non-empty, pop the head and latch the word.
  - If first_word or addr != exp_pc, go to A_SET; otherwise go to D_SET.
  - busy=1 in every state except IDLE with an empty FIFO, and DONE.
- A_SET: sw_data=addr. A_PRESS: load_pc_btn=1. A_REL: load_pc_btn=0.
- D_SET: sw_data=data. D_PRESS: deposit_btn=1. D_REL: deposit_btn=0.
- Exiting D_REL:
  - words_loaded++ (saturates at all-ones).
  - exp_pc = addr+1, wrapping mod 2^WORD_W, so 7777→0000.
  - first_word=0.
  - Go to S_SET if the word's last bit was set, else IDLE.
- S_SET/S_PRESS/S_REL: load START_ADDR with the same 3-phase sequence, then RUN_ARM.
- RUN_ARM: hold for HOLD_CYCLES, then run_sw=1 and go to RUNNING.
- RUNNING: run_sw stays 1. A run_led 1→0 edge (registered compare) goes to DONE.
  - run_led low before any rise does not finish; require a seen_high flag.
- DONE: done=1, run_sw=0, busy=0. Terminal until reset; in_ready=0.
- Invariants:
  - load_pc_btn and deposit_btn are never high together.
  - sw_data is stable across any phase in which a button is high.
- Per-word latency from pop:
  - Non-contiguous word: 6·HOLD_CYCLES+1 cycles.
  - Contiguous word: 3·HOLD_CYCLES+1 cycles.
- in_valid during DONE is ignored.

Decomposition:
- Shared package (CPU_Definitions.pkg):
  - loader_state_t enum.
  - Typedef image_word_t {logic last; word addr; word data;}.
  - Constant DEFAULT_START_ADDR=12'o0200.
- One sub-module: fp_loader_fifo (sync FIFO, parametrised WIDTH/DEPTH, outputs full/empty).
- The top level holds the FSM, the phase timer and exp_pc.

Test Plan (HOLD_CYCLES=2):
- Single word (0200,7402,last) → load_pc_btn high with sw_data=0200, then deposit_btn high with sw_data=7402. Start load 0200 follows. run_sw=1 at cycle 6·2+1+3·2+2 from pop. words_loaded=1.
- Contiguous 0200,0201,0202 → exactly one load_pc_btn pulse before the first deposit and one for START_ADDR, plus three deposit pulses.
- Gap case 0200 then 0300 → two Load-PC pulses with sw_data 0200 and 0300.
- Wrap case 7777 then 0000 → 0000 is treated as contiguous, so no Load-PC pulse for it.
- Backpressure: push 6 words back-to-back with FIFO_DEPTH=4 → in_ready deasserts after 4 unpopped entries, no word lost, deposit order matches input order.
- Reset asserted during D_PRESS → deposit_btn=0 immediately, FIFO empty, busy=0. run_led 0→1→0 after run → done=1 and sticky. run_led low from start → done stays 0.

Source files
------------

// File: rtl/fp_image_loader_pkg.sv
// Shared types and constants for the front-panel image loader.
package fp_image_loader_pkg;

  localparam int          DEFAULT_WORD_W     = 12;
  localparam logic [11:0] DEFAULT_START_ADDR = 12'o0200;

  typedef logic [DEFAULT_WORD_W-1:0] word;

  // One memory-image entry as offered on the input stream.
  typedef struct packed {
    logic last;
    word  addr;
    word  data;
  } image_word_t;

  // Loader sequencing states: three button phases per panel operation.
  typedef enum logic [3:0] {
    IDLE,
    A_SET,
    A_PRESS,
    A_REL,
    D_SET,
    D_PRESS,
    D_REL,
    S_SET,
    S_PRESS,
    S_REL,
    RUN_ARM,
    RUNNING,
    DONE
  } loader_state_t;

endpackage

// File: rtl/fp_image_loader_if.sv
// Valid/ready stream of (address, data, last) image words into the loader.
interface fp_image_loader_if #(
  parameter int WORD_W = 12
) ();

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_addr;
  logic [WORD_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/fp_loader_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module fp_loader_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; contents are only visible through the pointers.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fp_image_loader.sv
// Front-panel image loader: deposits buffered (addr, data) words through the
// Load-PC / Deposit buttons, then loads the start address and runs the CPU.
module fp_image_loader
  import fp_image_loader_pkg::*;
#(
  parameter int                WORD_W      = DEFAULT_WORD_W,
  parameter int                HOLD_CYCLES = 10,
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [WORD_W-1:0] START_ADDR  = WORD_W'(DEFAULT_START_ADDR),
  parameter int                CNT_W       = 13
) (
  input  logic              clock,
  input  logic              resetN,
  fp_image_loader_if.slave  img,
  output logic [WORD_W-1:0] sw_data,
  output logic              run_sw,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  input  logic              run_led,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  words_loaded
);

  localparam int FW    = 2 * WORD_W + 1;
  localparam int TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(HOLD_CYCLES - 1);

  loader_state_t     state;
  loader_state_t     state_next;

  logic [FW-1:0]     fifo_wdata;
  logic [FW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [WORD_W-1:0] head_addr;

  logic              cur_last;
  logic [WORD_W-1:0] cur_addr;
  logic [WORD_W-1:0] cur_data;

  logic [TMR_W-1:0]  tmr;
  logic              phase_done;

  logic [WORD_W-1:0] exp_pc;
  logic              first_word;
  logic              deposit_exit;

  logic              led_q;
  logic              seen_high;
  logic              led_fall;

  assign fifo_wdata   = {img.in_last, img.in_addr, img.in_data};
  assign fifo_push    = img.in_valid && img.in_ready;
  assign img.in_ready = !fifo_full && (state != DONE);
  assign head_addr    = fifo_rdata[2*WORD_W-1:WORD_W];

  fp_loader_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetN (resetN),
    .push   (fifo_push),
    .wdata  (fifo_wdata),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign phase_done   = (tmr == '0);
  assign deposit_exit = (state == D_REL) && phase_done;
  assign led_fall     = (state == RUNNING) && seen_high && led_q && !run_led;

  // State register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; the FIFO head is popped the cycle IDLE accepts it.
  always_comb begin
    state_next = state;
    fifo_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (first_word || (head_addr != exp_pc)) state_next = A_SET;
          else                                     state_next = D_SET;
        end
      end
      A_SET:   if (phase_done) state_next = A_PRESS;
      A_PRESS: if (phase_done) state_next = A_REL;
      A_REL:   if (phase_done) state_next = D_SET;
      D_SET:   if (phase_done) state_next = D_PRESS;
      D_PRESS: if (phase_done) state_next = D_REL;
      D_REL:   if (phase_done) state_next = cur_last ? S_SET : IDLE;
      S_SET:   if (phase_done) state_next = S_PRESS;
      S_PRESS: if (phase_done) state_next = S_REL;
      S_REL:   if (phase_done) state_next = RUN_ARM;
      RUN_ARM: if (phase_done) state_next = RUNNING;
      RUNNING: if (led_fall)   state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Phase timer reloads whenever a new state is entered and counts down to 0.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN)                  tmr <= '0;
    else if (state_next != state) tmr <= TMR_RELOAD;
    else if (tmr != '0)           tmr <= tmr - 1'b1;
  end

  // Latch the popped word so the switches stay put for the whole sequence.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cur_last <= 1'b0;
      cur_addr <= '0;
      cur_data <= '0;
    end else if (fifo_pop) begin
      cur_last <= fifo_rdata[FW-1];
      cur_addr <= head_addr;
      cur_data <= fifo_rdata[WORD_W-1:0];
    end
  end

  // Track where the CPU's PC will be after each deposit auto-increments it.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      words_loaded <= '0;
      exp_pc       <= '0;
      first_word   <= 1'b1;
    end else if (deposit_exit) begin
      if (words_loaded != '1) words_loaded <= words_loaded + 1'b1;
      exp_pc     <= cur_addr + 1'b1;
      first_word <= 1'b0;
    end
  end

  // Registered run LED plus a flag that it has gone high since run started.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      led_q     <= 1'b0;
      seen_high <= 1'b0;
    end else begin
      led_q <= run_led;
      if ((state == RUNNING) && run_led) seen_high <= 1'b1;
    end
  end

  // Front-panel drive decoded from the current phase.
  always_comb begin
    sw_data     = '0;
    load_pc_btn = 1'b0;
    deposit_btn = 1'b0;
    run_sw      = 1'b0;
    case (state)
      A_SET, A_REL: sw_data = cur_addr;
      A_PRESS: begin
        sw_data     = cur_addr;
        load_pc_btn = 1'b1;
      end
      D_SET, D_REL: sw_data = cur_data;
      D_PRESS: begin
        sw_data     = cur_data;
        deposit_btn = 1'b1;
      end
      S_SET, S_REL: sw_data = START_ADDR;
      S_PRESS: begin
        sw_data     = START_ADDR;
        load_pc_btn = 1'b1;
      end
      RUNNING: run_sw = 1'b1;
      default: ;
    endcase
  end

  assign busy = !(((state == IDLE) && fifo_empty) || (state == DONE));
  assign done = (state == DONE);

endmodule

// File: tb/tb_fp_image_loader.sv
// Self-checking bench: front-panel button events compared against a
// word-level model of what the operator sequence should have been.
module tb_fp_image_loader;
  import fp_image_loader_pkg::*;

  localparam int H  = 2;
  localparam int FD = 4;
  localparam int CW = 13;
  localparam int WW = 12;
  localparam logic [11:0] START = 12'o0200;

  logic          clock;
  logic          resetN;
  logic [WW-1:0] sw_data;
  logic          run_sw;
  logic          load_pc_btn;
  logic          deposit_btn;
  logic          run_led;
  logic          busy;
  logic          done;
  logic [CW-1:0] words_loaded;

  fp_image_loader_if #(.WORD_W(WW)) img_if ();

  fp_image_loader #(
    .WORD_W      (WW),
    .HOLD_CYCLES (H),
    .FIFO_DEPTH  (FD),
    .START_ADDR  (START),
    .CNT_W       (CW)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .img          (img_if),
    .sw_data      (sw_data),
    .run_sw       (run_sw),
    .load_pc_btn  (load_pc_btn),
    .deposit_btn  (deposit_btn),
    .run_led      (run_led),
    .busy         (busy),
    .done         (done),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  image_word_t cur_img[$];
  logic [12:0] obs_q[$];
  logic [12:0] exp_q[$];

  int          excl_viol;
  int          stab_viol;
  int          wid_viol;
  int          l_wid;
  int          d_wid;
  logic        prev_l;
  logic        prev_d;
  logic [11:0] hold_sw;
  logic        saw_stall;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Record every button press with the switch value, and police invariants.
  always @(negedge clock) begin
    if (!resetN) begin
      prev_l = 1'b0;
      prev_d = 1'b0;
      l_wid  = 0;
      d_wid  = 0;
    end else begin
      if (load_pc_btn && deposit_btn) excl_viol++;
      if (load_pc_btn && !prev_l) begin
        obs_q.push_back({1'b1, sw_data});
        hold_sw = sw_data;
      end
      if (deposit_btn && !prev_d) begin
        obs_q.push_back({1'b0, sw_data});
        hold_sw = sw_data;
      end
      if (((load_pc_btn && prev_l) || (deposit_btn && prev_d)) && (sw_data !== hold_sw)) stab_viol++;
      if (load_pc_btn) l_wid++;
      else begin
        if (prev_l && (l_wid != H)) wid_viol++;
        l_wid = 0;
      end
      if (deposit_btn) d_wid++;
      else begin
        if (prev_d && (d_wid != H)) wid_viol++;
        d_wid = 0;
      end
      prev_l = load_pc_btn;
      prev_d = deposit_btn;
    end
  end

  // Operator model: Load PC whenever the PC is not already at the address.
  task automatic buildExpected();
    logic [11:0] pc;
    bit          first;
    pc    = '0;
    first = 1'b1;
    exp_q.delete();
    foreach (cur_img[i]) begin
      if (first || (cur_img[i].addr != pc)) exp_q.push_back({1'b1, cur_img[i].addr});
      exp_q.push_back({1'b0, cur_img[i].data});
      pc    = cur_img[i].addr + 12'd1;
      first = 1'b0;
      if (cur_img[i].last) exp_q.push_back({1'b1, START});
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    resetN          = 1'b0;
    img_if.in_valid = 1'b0;
    run_led         = 1'b0;
    repeat (2) @(negedge clock);
    obs_q.delete();
    excl_viol = 0;
    stab_viol = 0;
    wid_viol  = 0;
    @(negedge clock);
    resetN = 1'b1;
  endtask

  // Offer one word after 'gap' idle cycles and hold it until accepted.
  task automatic applyStimulus(input image_word_t w, input int gap);
    int   waited;
    logic rdy;
    repeat (gap) begin
      @(negedge clock);
      img_if.in_valid = 1'b0;
    end
    @(negedge clock);
    img_if.in_valid = 1'b1;
    img_if.in_addr  = w.addr;
    img_if.in_data  = w.data;
    img_if.in_last  = w.last;
    waited = 0;
    while (1) begin
      rdy = img_if.in_ready;
      if (!rdy) saw_stall = 1'b1;
      @(posedge clock);
      if (rdy) break;
      waited++;
      if (waited > 500) begin
        checkOutput("push_timeout", 1, 0);
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic pushImage(input int gap_max);
    foreach (cur_img[i]) applyStimulus(cur_img[i], $urandom_range(0, gap_max));
    @(negedge clock);
    img_if.in_valid = 1'b0;
  endtask

  task automatic waitRunSw();
    int n;
    n = 0;
    while (!run_sw && (n < 2000)) begin
      @(negedge clock);
      n++;
    end
    checkOutput("run_sw_timeout", {31'd0, !run_sw}, 0);
  endtask

  // Play the CPU: LED low for a while, then high, then low to finish.
  task automatic finishRun(input int low_cycles, input int high_cycles, input int exp_words);
    checkOutput("words_at_run", words_loaded, exp_words);
    repeat (low_cycles) @(negedge clock);
    checkOutput("no_done_led_low", done, 0);
    checkOutput("busy_running", busy, 1);
    run_led = 1'b1;
    repeat (high_cycles) @(negedge clock);
    checkOutput("no_done_led_high", done, 0);
    run_led = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("done_set", done, 1);
    checkOutput("busy_done", busy, 0);
    checkOutput("run_sw_done", run_sw, 0);
    checkOutput("ready_done", img_if.in_ready, 0);
    img_if.in_valid = 1'b1;
    img_if.in_addr  = 12'($urandom);
    img_if.in_data  = 12'($urandom);
    img_if.in_last  = 1'b1;
    run_led = 1'b1;
    repeat (4) @(negedge clock);
    img_if.in_valid = 1'b0;
    run_led = 1'b0;
    repeat (4) @(negedge clock);
    checkOutput("done_sticky", done, 1);
    checkOutput("words_after_done", words_loaded, exp_words);
  endtask

  task automatic compareEvents(input string name);
    int n;
    checkOutput({name, "_ev_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s_ev%0d", name, i), obs_q[i], exp_q[i]);
    checkOutput({name, "_btn_excl"}, excl_viol, 0);
    checkOutput({name, "_sw_stable"}, stab_viol, 0);
    checkOutput({name, "_btn_width"}, wid_viol, 0);
  endtask

  task automatic runImage(input string name, input int gap_max, input int low_cycles);
    doReset();
    buildExpected();
    pushImage(gap_max);
    waitRunSw();
    finishRun(low_cycles, $urandom_range(1, 4), cur_img.size());
    compareEvents(name);
  endtask

  function automatic image_word_t mkWord(input logic [11:0] a, input logic [11:0] d, input logic l);
    image_word_t w;
    w.addr = a;
    w.data = d;
    w.last = l;
    return w;
  endfunction

  initial begin
    int n_l, n_d, n_r, n;
    logic [11:0] a;

    resetN          = 1'b1;
    run_led         = 1'b0;
    img_if.in_valid = 1'b0;
    img_if.in_addr  = '0;
    img_if.in_data  = '0;
    img_if.in_last  = 1'b0;
    saw_stall       = 1'b0;
    excl_viol       = 0;
    stab_viol       = 0;
    wid_viol        = 0;

    // Reset values.
    doReset();
    #1;
    checkOutput("rst_in_ready", img_if.in_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_words", words_loaded, 0);
    checkOutput("rst_sw_data", sw_data, 0);
    checkOutput("rst_run_sw", run_sw, 0);
    checkOutput("rst_load_btn", load_pc_btn, 0);
    checkOutput("rst_dep_btn", deposit_btn, 0);

    // Single word with phase timing measured from the accepting edge.
    cur_img = '{mkWord(12'o0200, 12'o7402, 1'b1)};
    buildExpected();
    applyStimulus(cur_img[0], 0);
    n_l = 0; n_d = 0; n_r = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clock);
      img_if.in_valid = 1'b0;
      if (load_pc_btn && (n_l == 0)) n_l = i;
      if (deposit_btn && (n_d == 0)) n_d = i;
      if (run_sw) begin
        n_r = i;
        break;
      end
    end
    checkOutput("single_load_cycle", n_l, H + 2);
    checkOutput("single_dep_cycle", n_d, 4 * H + 2);
    checkOutput("single_run_cycle", n_r, 10 * H + 2);
    finishRun(2, 2, 1);
    compareEvents("single");

    // Contiguous run with the LED held low for a long time first.
    cur_img = '{mkWord(12'o0200, 12'o1111, 1'b0), mkWord(12'o0201, 12'o2222, 1'b0),
                mkWord(12'o0202, 12'o3333, 1'b1)};
    runImage("contig", 0, 30);

    // Address gap forces a second Load PC.
    cur_img = '{mkWord(12'o0200, 12'o0001, 1'b0), mkWord(12'o0300, 12'o0002, 1'b1)};
    runImage("gap", 2, 2);

    // PC wrap 7777 -> 0000 counts as contiguous.
    cur_img = '{mkWord(12'o7777, 12'o4444, 1'b0), mkWord(12'o0000, 12'o5555, 1'b1)};
    runImage("wrap", 1, 2);

    // Back-to-back burst larger than the FIFO.
    cur_img.delete();
    for (int i = 0; i < 6; i++) cur_img.push_back(mkWord(12'(12'o0400 + i), 12'($urandom), i == 5));
    doReset();
    saw_stall = 1'b0;
    buildExpected();
    pushImage(0);
    checkOutput("burst_stall_seen", saw_stall, 1);
    waitRunSw();
    finishRun(1, 1, 6);
    compareEvents("burst");

    // Reset while the deposit button is pressed.
    cur_img.delete();
    for (int i = 0; i < 3; i++) cur_img.push_back(mkWord(12'(12'o0500 + i), 12'($urandom), 1'b0));
    doReset();
    foreach (cur_img[i]) applyStimulus(cur_img[i], 0);
    @(negedge clock);
    img_if.in_valid = 1'b0;
    n = 0;
    while (!deposit_btn && (n < 200)) begin
      @(negedge clock);
      n++;
    end
    checkOutput("mid_dep_seen", deposit_btn, 1);
    resetN = 1'b0;
    #1;
    checkOutput("mid_rst_dep_btn", deposit_btn, 0);
    checkOutput("mid_rst_load_btn", load_pc_btn, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", img_if.in_ready, 1);
    checkOutput("mid_rst_words", words_loaded, 0);
    repeat (2) @(negedge clock);
    obs_q.delete();
    resetN = 1'b1;
    repeat (30) @(negedge clock);
    checkOutput("mid_rst_no_events", obs_q.size(), 0);
    checkOutput("mid_rst_idle", busy, 0);

    // Randomized images.
    for (int t = 0; t < 8; t++) begin
      cur_img.delete();
      n = $urandom_range(1, 6);
      a = ($urandom_range(0, 3) == 0) ? 12'o7775 : 12'($urandom);
      for (int i = 0; i < n; i++) begin
        cur_img.push_back(mkWord(a, 12'($urandom), i == n - 1));
        a = ($urandom_range(0, 9) < 6) ? a + 12'd1 : 12'($urandom);
      end
      runImage($sformatf("rand%0d", t), 3, $urandom_range(0, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
